// File: rtl/ace_kbd_pkg.sv
// Shared types, constants and lookup functions for the PS/2 to Jupiter Ace keyboard bridge.
// Contents:
//   dec_state_t  : scan-code decoder states
//   CODE_*       : PS/2 prefix bytes (E0 extended, F0 break, E1 pause)
//   ROW_*/COL_*  : Ace key-matrix coordinates (row = A[8+n], col = data bit)
//   keymap()     : 9-bit code {ext, byte} -> {hit, row, col}
//   dup_key()    : codes that alias a matrix key but are tracked on their own bit
//   cursor_key() : arrow codes, used only when ACE_CURSOR_KEYS_EN is defined
//   is_ignored() : keyboard housekeeping bytes that never reach the matrix
package ace_kbd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_REL,
      ST_EXT_REL,
      ST_SKIP
   } dec_state_t;

   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;
   localparam logic [7:0] CODE_E1 = 8'hE1;

   // Bytes following E1 in the Pause sequence: 14 77 E1 F0 14 F0 77
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam logic [2:0] ROW_SHIFT = 3'd0;  // SHIFT SYM Z X C
   localparam logic [2:0] ROW_ASDFG = 3'd1;
   localparam logic [2:0] ROW_QWERT = 3'd2;
   localparam logic [2:0] ROW_12345 = 3'd3;
   localparam logic [2:0] ROW_09876 = 3'd4;
   localparam logic [2:0] ROW_POIUY = 3'd5;
   localparam logic [2:0] ROW_ENTER = 3'd6;  // ENTER L K J H
   localparam logic [2:0] ROW_SPACE = 3'd7;  // SPACE M N B V

   localparam logic [2:0] COL_0 = 3'd0;
   localparam logic [2:0] COL_1 = 3'd1;
   localparam logic [2:0] COL_2 = 3'd2;
   localparam logic [2:0] COL_3 = 3'd3;
   localparam logic [2:0] COL_4 = 3'd4;

   typedef struct packed {
      logic       hit;
      logic [2:0] row;
      logic [2:0] col;
   } key_loc_t;

   function automatic key_loc_t loc(input logic [2:0] row, input logic [2:0] col);
      key_loc_t k;
      k.hit = 1'b1;
      k.row = row;
      k.col = col;
      return k;
   endfunction

   // Scan-code set 2 to Ace matrix; code[8] marks an E0-prefixed key.
   function automatic key_loc_t keymap(input logic [8:0] code);
      key_loc_t k;
      k = '0;
      case (code)
         9'h012: k = loc(ROW_SHIFT, COL_0);  // left shift
         9'h014: k = loc(ROW_SHIFT, COL_1);  // left ctrl -> SYM
         9'h01A: k = loc(ROW_SHIFT, COL_2);
         9'h022: k = loc(ROW_SHIFT, COL_3);
         9'h021: k = loc(ROW_SHIFT, COL_4);
         9'h01C: k = loc(ROW_ASDFG, COL_0);
         9'h01B: k = loc(ROW_ASDFG, COL_1);
         9'h023: k = loc(ROW_ASDFG, COL_2);
         9'h02B: k = loc(ROW_ASDFG, COL_3);
         9'h034: k = loc(ROW_ASDFG, COL_4);
         9'h015: k = loc(ROW_QWERT, COL_0);
         9'h01D: k = loc(ROW_QWERT, COL_1);
         9'h024: k = loc(ROW_QWERT, COL_2);
         9'h02D: k = loc(ROW_QWERT, COL_3);
         9'h02C: k = loc(ROW_QWERT, COL_4);
         9'h016: k = loc(ROW_12345, COL_0);
         9'h01E: k = loc(ROW_12345, COL_1);
         9'h026: k = loc(ROW_12345, COL_2);
         9'h025: k = loc(ROW_12345, COL_3);
         9'h02E: k = loc(ROW_12345, COL_4);
         9'h045: k = loc(ROW_09876, COL_0);
         9'h046: k = loc(ROW_09876, COL_1);
         9'h03E: k = loc(ROW_09876, COL_2);
         9'h03D: k = loc(ROW_09876, COL_3);
         9'h036: k = loc(ROW_09876, COL_4);
         9'h04D: k = loc(ROW_POIUY, COL_0);
         9'h044: k = loc(ROW_POIUY, COL_1);
         9'h043: k = loc(ROW_POIUY, COL_2);
         9'h03C: k = loc(ROW_POIUY, COL_3);
         9'h035: k = loc(ROW_POIUY, COL_4);
         9'h05A: k = loc(ROW_ENTER, COL_0);
         9'h04B: k = loc(ROW_ENTER, COL_1);
         9'h042: k = loc(ROW_ENTER, COL_2);
         9'h03B: k = loc(ROW_ENTER, COL_3);
         9'h033: k = loc(ROW_ENTER, COL_4);
         9'h029: k = loc(ROW_SPACE, COL_0);
         9'h03A: k = loc(ROW_SPACE, COL_1);
         9'h031: k = loc(ROW_SPACE, COL_2);
         9'h032: k = loc(ROW_SPACE, COL_3);
         9'h02A: k = loc(ROW_SPACE, COL_4);
         default: k = '0;
      endcase
      return k;
   endfunction

   // Right shift (bit0 -> SHIFT) and right ctrl (bit1 -> SYM) keep their own
   // state so releasing one twin does not drop the other.
   function automatic logic [1:0] dup_key(input logic [8:0] code);
      case (code)
         9'h059:  return 2'b01;
         9'h114:  return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   // Arrows left/down/up/right -> one-hot virtual SHIFT+5/6/7/8.
   function automatic logic [3:0] cursor_key(input logic [8:0] code);
      case (code)
         9'h16B:  return 4'b0001;
         9'h172:  return 4'b0010;
         9'h175:  return 4'b0100;
         9'h174:  return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: 2-FF synchroniser, clock glitch filter, 11-bit frame
// shifter with start/parity/stop checks and a mid-frame timeout.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   ps2clk, ps2data asynchronous PS/2 lines
//   rx_byte         last good data byte
//   byte_valid      1-cycle strobe, cycle after the stop-bit edge
//   err             1-cycle strobe on bad start/parity/stop or timeout
module ps2_rx_frame #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 32500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2clk,
   input  logic       ps2data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_filt;
   logic          clk_filt_d;
   logic [FW-1:0] filt_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;
   logic [TW-1:0] to_cnt;
   logic          fall_c;

   assign fall_c = clk_filt_d & ~clk_filt;

   // Synchroniser and filter: a new clock level needs FILTER_LEN samples in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2clk};
         data_sync  <= {data_sync[0], ps2data};
         clk_filt_d <= clk_filt;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   // Frame shifter: bit 0 start, bits 1..9 data+parity into shreg, bit 10 stop.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         to_cnt     <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         err        <= 1'b0;
         if (fall_c) begin
            to_cnt <= '0;
            case (bit_cnt)
               4'd0: begin
                  if (data_sync[1]) err <= 1'b1;
                  else              bit_cnt <= 4'd1;
               end
               4'd10: begin
                  bit_cnt <= '0;
                  // shreg holds {parity, data}; odd parity means odd popcount
                  if (data_sync[1] && (^shreg)) begin
                     rx_byte    <= shreg[7:0];
                     byte_valid <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
               default: begin
                  if (bit_cnt > 4'd10) begin
                     bit_cnt <= '0;
                  end else begin
                     shreg   <= {data_sync[1], shreg[8:1]};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            endcase
         end else if (bit_cnt != 4'd0) begin
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               err     <= 1'b1;
               bit_cnt <= '0;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_ace_keyboard.sv
// PS/2 keyboard to Jupiter Ace 8x5 key matrix.
// Ports:
//   clk, reset  system clock (Ace logic clock), synchronous active-high reset
//   ps2clk      PS/2 clock (asynchronous)
//   ps2data     PS/2 data (asynchronous)
//   filas       row select, active low, bit n = A[8+n]
//   columnas    column return, active low, combinational from filas
//   kbd_err     1-cycle pulse on a receive error or timeout
// Build option: ACE_CURSOR_KEYS_EN maps the arrow keys to SHIFT+5/6/7/8.
module ps2_ace_keyboard
   import ace_kbd_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 32500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2clk,
   input  logic       ps2data,
   input  logic [7:0] filas,
   output logic [4:0] columnas,
   output logic       kbd_err
);

   logic [7:0]      rx_byte;
   logic            rx_valid;
   dec_state_t      state;
   logic [2:0]      skip_cnt;
   logic [7:0][4:0] matrix;
   logic [1:0]      dup_held;
   logic [7:0][4:0] pressed_c;
   logic            key_act_c;
   logic            key_make_c;
   logic [8:0]      key_code_c;
   key_loc_t        key_loc_c;
   logic [1:0]      key_dup_c;
   logic [4:0]      col_hit_c;

   ps2_rx_frame #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .ps2clk     (ps2clk),
      .ps2data    (ps2data),
      .rx_byte    (rx_byte),
      .byte_valid (rx_valid),
      .err        (kbd_err)
   );

   // Decoder FSM: tracks prefixes and the Pause-sequence skip.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         skip_cnt <= '0;
      end else if (rx_valid) begin
         case (state)
            ST_IDLE: begin
               if (rx_byte == CODE_E0) begin
                  state <= ST_EXT;
               end else if (rx_byte == CODE_F0) begin
                  state <= ST_REL;
               end else if (rx_byte == CODE_E1) begin
                  state    <= ST_SKIP;
                  skip_cnt <= PAUSE_SKIP;
               end
            end
            ST_EXT:     state <= (rx_byte == CODE_F0) ? ST_EXT_REL : ST_IDLE;
            ST_REL:     state <= ST_IDLE;
            ST_EXT_REL: state <= ST_IDLE;
            ST_SKIP: begin
               skip_cnt <= skip_cnt - 3'd1;
               if (skip_cnt == 3'd1) state <= ST_IDLE;
            end
            default:    state <= ST_IDLE;
         endcase
      end
   end

   // Make/break request for the byte arriving this cycle.
   always_comb begin
      key_act_c  = 1'b0;
      key_make_c = 1'b0;
      key_code_c = {1'b0, rx_byte};
      case (state)
         ST_IDLE: begin
            key_act_c  = rx_valid && (rx_byte != CODE_E0) && (rx_byte != CODE_F0) &&
                         (rx_byte != CODE_E1) && !is_ignored(rx_byte);
            key_make_c = 1'b1;
         end
         ST_EXT: begin
            key_act_c  = rx_valid && (rx_byte != CODE_F0);
            key_make_c = 1'b1;
            key_code_c = {1'b1, rx_byte};
         end
         ST_REL: begin
            key_act_c = rx_valid;
         end
         ST_EXT_REL: begin
            key_act_c  = rx_valid;
            key_code_c = {1'b1, rx_byte};
         end
         default: key_act_c = 1'b0;
      endcase
   end

   assign key_loc_c = keymap(key_code_c);
   assign key_dup_c = dup_key(key_code_c);

   // Key state; unmapped codes fall through both branches untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         matrix   <= '0;
         dup_held <= '0;
      end else if (key_act_c) begin
         if (key_dup_c != 2'b00) begin
            dup_held <= key_make_c ? (dup_held | key_dup_c) : (dup_held & ~key_dup_c);
         end else if (key_loc_c.hit) begin
            matrix[key_loc_c.row][key_loc_c.col] <= key_make_c;
         end
      end
   end

`ifdef ACE_CURSOR_KEYS_EN
   logic [3:0] virt;
   logic [3:0] key_cur_c;

   assign key_cur_c = cursor_key(key_code_c);

   // Arrow keys live apart from the matrix so they never clear a real key.
   always_ff @(posedge clk) begin
      if (reset) begin
         virt <= '0;
      end else if (key_act_c && (key_cur_c != 4'b0000)) begin
         virt <= key_make_c ? (virt | key_cur_c) : (virt & ~key_cur_c);
      end
   end
`endif

   // Effective key state: matrix plus the separately tracked twins/virtual keys.
   always_comb begin
      pressed_c = matrix;
      pressed_c[ROW_SHIFT][COL_0] = matrix[ROW_SHIFT][COL_0] | dup_held[0];
      pressed_c[ROW_SHIFT][COL_1] = matrix[ROW_SHIFT][COL_1] | dup_held[1];
`ifdef ACE_CURSOR_KEYS_EN
      pressed_c[ROW_SHIFT][COL_0] = pressed_c[ROW_SHIFT][COL_0] | (|virt);
      pressed_c[ROW_12345][COL_4] = pressed_c[ROW_12345][COL_4] | virt[0];
      pressed_c[ROW_09876][COL_4] = pressed_c[ROW_09876][COL_4] | virt[1];
      pressed_c[ROW_09876][COL_3] = pressed_c[ROW_09876][COL_3] | virt[2];
      pressed_c[ROW_09876][COL_2] = pressed_c[ROW_09876][COL_2] | virt[3];
`endif
   end

   // Column mux: every selected row contributes; no clock in this path.
   always_comb begin
      col_hit_c = '0;
      for (int r = 0; r < 8; r++) begin
         if (!filas[r]) col_hit_c = col_hit_c | pressed_c[r];
      end
      columnas = ~col_hit_c;
   end

endmodule

// File: tb/tb_ps2_ace_keyboard.sv
// Testbench for ps2_ace_keyboard: directed scenarios plus randomized key
// traffic checked against a key-set reference model.
module tb_ps2_ace_keyboard;

   localparam int unsigned HALF = 20;    // PS/2 half period in clk cycles
   localparam int unsigned TO   = 1000;  // timeout used for this bench

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2clk = 1'b1;
   logic       ps2data = 1'b1;
   logic [7:0] filas = 8'hFF;
   logic [4:0] columnas;
   logic       kbd_err;

   int errors = 0;
   int checks = 0;
   int err_pulses = 0;

   // Reference model: set of held codes {ext, byte} plus prefix flags.
   bit held [512];
   bit m_ext, m_rel;
   int m_skip;

   logic [8:0] keytab [40] = '{
      9'h012, 9'h014, 9'h01A, 9'h022, 9'h021,
      9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,
      9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
      9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
      9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036,
      9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035,
      9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033,
      9'h029, 9'h03A, 9'h031, 9'h032, 9'h02A};
   logic [8:0] arrows [4] = '{9'h16B, 9'h172, 9'h175, 9'h174};
   logic [8:0] unmapped [3] = '{9'h00E, 9'h112, 9'h066};

   ps2_ace_keyboard #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2clk   (ps2clk),
      .ps2data  (ps2data),
      .filas    (filas),
      .columnas (columnas),
      .kbd_err  (kbd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (kbd_err === 1'b1) err_pulses++;

   function automatic void model_reset();
      for (int i = 0; i < 512; i++) held[i] = 1'b0;
      m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int idx;
      idx = (m_ext ? 256 : 0) + int'(b);
      if (m_skip > 0) m_skip--;
      else if (m_rel) begin held[idx] = 1'b0; m_ext = 1'b0; m_rel = 1'b0; end
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (m_ext) begin held[idx] = 1'b1; m_ext = 1'b0; end
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) held[idx] = 1'b1;
   endfunction

   function automatic logic [4:0] model_cols(input logic [7:0] f);
      logic [4:0] acc;
      bit p;
      acc = '0;
      for (int r = 0; r < 8; r++) begin
         if (!f[r]) begin
            for (int c = 0; c < 5; c++) begin
               p = held[keytab[r*5+c]];
               if (r == 0 && c == 0) p = p | held[9'h059];
               if (r == 0 && c == 1) p = p | held[9'h114];
`ifdef ACE_CURSOR_KEYS_EN
               if (r == 0 && c == 0) p = p | held[9'h16B] | held[9'h172] | held[9'h175] | held[9'h174];
               if (r == 3 && c == 4) p = p | held[9'h16B];
               if (r == 4 && c == 4) p = p | held[9'h172];
               if (r == 4 && c == 3) p = p | held[9'h175];
               if (r == 4 && c == 2) p = p | held[9'h174];
`endif
               if (p) acc[c] = 1'b1;
            end
         end
      end
      return ~acc;
   endfunction

   // Drive the first nbits of an 11-bit frame; flip corrupts the parity bit.
   task automatic send_frame(input logic [7:0] b, input bit flip, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk); ps2data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2clk = 1'b1;
      end
      @(negedge clk); ps2data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 11);
      model_byte(b);
   endtask

   task automatic send_key(input logic [8:0] code, input bit brk);
      if (code[8]) send_byte(8'hE0);
      if (brk) send_byte(8'hF0);
      send_byte(code[7:0]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      filas = 8'h00; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL reset_cols got=%b want=11111", columnas); end
      checks++;
      if (kbd_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", kbd_err); end
      @(negedge clk); reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_make();
      send_byte(8'h1C);
      @(negedge clk); filas = 8'hFD; #1;
      checks++;
      if (columnas !== 5'b11110) begin errors++; $display("FAIL make_a_row1 got=%b want=11110", columnas); end
      filas = 8'hFB; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL make_a_row2 got=%b want=11111", columnas); end
      checks++;
      if (err_pulses !== 0) begin errors++; $display("FAIL make_no_err got=%0d want=0", err_pulses); end
   endtask

   task automatic test_break();
      send_byte(8'h1B);
      send_byte(8'hF0); send_byte(8'h1C);
      @(negedge clk); filas = 8'hFD; #1;
      checks++;
      if (columnas !== 5'b11101) begin errors++; $display("FAIL break_a got=%b want=11101", columnas); end
      send_byte(8'hF0); send_byte(8'h1B);
      @(negedge clk); filas = 8'hFD; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL break_s got=%b want=11111", columnas); end
   endtask

   task automatic test_shift_pair();
      send_byte(8'h12); send_byte(8'h59);
      send_byte(8'hF0); send_byte(8'h12);
      @(negedge clk); filas = 8'hFE; #1;
      checks++;
      if (columnas !== 5'b11110) begin errors++; $display("FAIL shift_rshift_held got=%b want=11110", columnas); end
      send_byte(8'hF0); send_byte(8'h59);
      @(negedge clk); filas = 8'hFE; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL shift_both_released got=%b want=11111", columnas); end
   endtask

   task automatic test_errors();
      int e0;
      e0 = err_pulses;
      send_frame(8'h1A, 1'b1, 11);
      checks++;
      if (err_pulses - e0 !== 1) begin errors++; $display("FAIL parity_err pulses got=%0d want=1", err_pulses - e0); end
      @(negedge clk); filas = 8'hFE; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL parity_dropped got=%b want=11111", columnas); end
      e0 = err_pulses;
      send_frame(8'h1A, 1'b0, 4);
      repeat (TO + 50) @(negedge clk);
      checks++;
      if (err_pulses - e0 !== 1) begin errors++; $display("FAIL timeout_err pulses got=%0d want=1", err_pulses - e0); end
      e0 = err_pulses;
      send_byte(8'h1A);
      @(negedge clk); filas = 8'hFE; #1;
      checks++;
      if (columnas !== 5'b11011) begin errors++; $display("FAIL after_timeout got=%b want=11011", columnas); end
      checks++;
      if (err_pulses - e0 !== 0) begin errors++; $display("FAIL after_timeout_err got=%0d want=0", err_pulses - e0); end
      send_byte(8'hF0); send_byte(8'h1A);
   endtask

   task automatic test_cursor();
      logic [4:0] want;
      send_byte(8'hE0); send_byte(8'h6B);
`ifdef ACE_CURSOR_KEYS_EN
      want = 5'b01110;
`else
      want = 5'b11111;
`endif
      @(negedge clk); filas = 8'hF6; #1;
      checks++;
      if (columnas !== want) begin errors++; $display("FAIL cursor_left got=%b want=%b", columnas, want); end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
      @(negedge clk); filas = 8'hF6; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL cursor_release got=%b want=11111", columnas); end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send_byte(seq[i]);
      send_byte(8'h1C);
      @(negedge clk); filas = 8'h00; #1;
      checks++;
      if (columnas !== 5'b11110) begin errors++; $display("FAIL pause_all_rows got=%b want=11110", columnas); end
      filas = 8'hFE; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL pause_no_sym got=%b want=11111", columnas); end
      send_byte(8'hF0); send_byte(8'h1C);
   endtask

   task automatic test_random();
      logic [8:0] code;
      logic [7:0] f;
      logic [4:0] want;
      int sel;
      for (int it = 0; it < 25; it++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6)       code = keytab[$urandom_range(0, 39)];
         else if (sel == 6) code = 9'h059;
         else if (sel == 7) code = 9'h114;
         else if (sel == 8) code = arrows[$urandom_range(0, 3)];
         else               code = unmapped[$urandom_range(0, 2)];
         send_key(code, ($urandom_range(0, 9) < 4));
         for (int k = 0; k < 3; k++) begin
            if (k == 0)      f = 8'hFF;
            else if (k == 1) f = ~(8'h01 << $urandom_range(0, 7));
            else             f = 8'($urandom_range(0, 255));
            @(negedge clk); filas = f; #1;
            want = model_cols(f);
            checks++;
            if (columnas !== want) begin
               errors++;
               $display("FAIL random it=%0d code=%h filas=%h got=%b want=%b", it, code, f, columnas, want);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] codes [6];
      logic [7:0] f;
      logic [4:0] want;
      for (int i = 0; i < 6; i++) begin
         codes[i] = keytab[$urandom_range(0, 39)];
         send_byte(codes[i][7:0]);
      end
      for (int r = 0; r <= 8; r++) begin
         f = (r == 8) ? 8'h00 : ~(8'h01 << r);
         @(negedge clk); filas = f; #1;
         want = model_cols(f);
         checks++;
         if (columnas !== want) begin errors++; $display("FAIL b2b filas=%h got=%b want=%b", f, columnas, want); end
      end
      for (int i = 0; i < 6; i++) begin
         send_byte(8'hF0); send_byte(codes[i][7:0]);
      end
      @(negedge clk); filas = 8'h00; #1;
      want = model_cols(8'h00);
      checks++;
      if (columnas !== want) begin errors++; $display("FAIL b2b_release got=%b want=%b", columnas, want); end
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'h16);
      send_frame(8'h1C, 1'b0, 5);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      filas = 8'h00; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL midreset_cols got=%b want=11111", columnas); end
      @(negedge clk); reset = 1'b0;
      repeat (5) @(negedge clk);
      send_byte(8'h1C);
      @(negedge clk); filas = 8'hFD; #1;
      checks++;
      if (columnas !== 5'b11110) begin errors++; $display("FAIL midreset_next got=%b want=11110", columnas); end
      filas = 8'hF7; #1;
      checks++;
      if (columnas !== 5'b11111) begin errors++; $display("FAIL midreset_row3 got=%b want=11111", columnas); end
   endtask

   initial begin
      test_reset();
      test_make();
      test_break();
      test_shift_pair();
      test_errors();
      test_cursor();
      test_pause();
      test_random();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
